// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// redirect bubbles, data-memory freezes, fetch bubbles and stall/flush statistics.

module pipe_hazard_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic in_redir,
  input logic redirect
);

  // EX only carries bubbles while redirect bubbles drain, so a redirect there is a bug upstream
  a_no_redirect_in_redir : assert property (@(posedge clk) disable iff (rst) !(in_redir && redirect));

endmodule

module pipe_hazard_ctrl #(
  parameter int REG_W            = 5,
  parameter int CNT_W            = 16,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  localparam logic [2:0]       BUBBLES_C = 3'(REDIRECT_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] REG_ZERO_C = {REG_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2:0]       bcnt_r;
  logic [2:0]       bcnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             load_use_s;
  logic             pc_load_s;
  logic             if_id_load_s;
  logic             if_id_flush_s;
  logic             id_ex_flush_s;

  assign load_use_s = ex_mem_read && (ex_rt != REG_ZERO_C) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and same-cycle control outputs
  always_comb begin
    state_nxt_s   = state_r;
    bcnt_nxt_s    = bcnt_r;
    pc_load_s     = 1'b0;
    if_id_load_s  = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (rst) begin
      state_nxt_s   = ST_RUN;
      bcnt_nxt_s    = 3'd0;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      case (state_r)
        // MWAIT re-evaluates the RUN rules on the cycle dmem_busy drops
        ST_RUN, ST_MWAIT: begin
          if (dmem_busy) begin
            state_nxt_s = ST_MWAIT;
          end else if (redirect) begin
            pc_load_s     = 1'b1;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            if (BUBBLES_C != 3'd0) begin
              state_nxt_s = ST_REDIR;
              bcnt_nxt_s  = BUBBLES_C;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else if (load_use_s) begin
            state_nxt_s   = ST_RUN;
            id_ex_flush_s = 1'b1;
          end else if (!imem_ready) begin
            state_nxt_s   = ST_RUN;
            if_id_flush_s = 1'b1;
          end else begin
            state_nxt_s  = ST_RUN;
            pc_load_s    = 1'b1;
            if_id_load_s = 1'b1;
          end
        end
        ST_REDIR: begin
          if (dmem_busy) begin
            state_nxt_s = ST_REDIR;
          end else begin
            pc_load_s     = imem_ready;
            if_id_flush_s = 1'b1;
            if (imem_ready && (bcnt_r <= 3'd1)) begin
              state_nxt_s = ST_RUN;
              bcnt_nxt_s  = 3'd0;
            end else if (imem_ready) begin
              bcnt_nxt_s = bcnt_r - 3'd1;
            end else begin
              bcnt_nxt_s = bcnt_r;
            end
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          bcnt_nxt_s  = 3'd0;
        end
      endcase
    end
  end

  // State and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      bcnt_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
    end
  end

  // Saturating statistics; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_load_s && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
      end
      if (if_id_flush_s && (flush_cnt_r != CNT_MAX_C)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
      end
    end
  end

  assign pc_load     = pc_load_s;
  assign if_id_load  = if_id_load_s;
  assign if_id_flush = if_id_flush_s;
  assign id_ex_flush = id_ex_flush_s;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

  pipe_hazard_ctrl_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_redir (state_r == ST_REDIR),
    .redirect (redirect)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// stimulus, all compared against a behavioural model of the hazard rules.

module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int RB    = 2;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = 5'd0;
  logic [REG_W-1:0] id_rt = 5'd0;
  logic             id_uses_rt = 1'b0;
  logic             ex_mem_read = 1'b0;
  logic [REG_W-1:0] ex_rt = 5'd0;
  logic             redirect = 1'b0;
  logic             imem_ready = 1'b0;
  logic             dmem_busy = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             pc_load, if_id_load, if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bubbles still owed after a redirect, plus the two statistics
  int m_bub   = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .REDIRECT_BUBBLES(RB)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .redirect(redirect),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive on the falling edge, check the combinational response, advance the model
  task automatic step(input int rs, input int rt, input bit urt, input bit mr, input int ert,
                      input bit rd, input bit imr, input bit busy, input bit clr, input bit r);
    bit e_pc, e_ifl, e_iff, e_idf, lu;
    @(negedge clk);
    id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt; ex_mem_read = mr; ex_rt = 5'(ert);
    redirect = rd; imem_ready = imr; dmem_busy = busy; cnt_clr = clr; rst = r;
    #1;
    lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    e_pc = 1'b0; e_ifl = 1'b0; e_iff = 1'b0; e_idf = 1'b0;
    if (r) begin
      m_bub = 0; m_stall = 0; m_flush = 0;
      e_iff = 1'b1; e_idf = 1'b1;
    end else if (m_bub > 0) begin
      if (!busy) begin
        e_pc = imr; e_iff = 1'b1;
        if (imr) m_bub--;
      end
    end else if (busy) begin
      e_pc = 1'b0;
    end else if (rd) begin
      e_pc = 1'b1; e_iff = 1'b1; e_idf = 1'b1; m_bub = RB;
    end else if (lu) begin
      e_idf = 1'b1;
    end else if (!imr) begin
      e_iff = 1'b1;
    end else begin
      e_pc = 1'b1; e_ifl = 1'b1;
    end
    check_eq("stall_cnt", int'(stall_cnt), m_stall);
    check_eq("flush_cnt", int'(flush_cnt), m_flush);
    check_eq("pc_load", int'(pc_load), int'(e_pc));
    check_eq("if_id_load", int'(if_id_load), int'(e_ifl));
    check_eq("if_id_flush", int'(if_id_flush), int'(e_iff));
    check_eq("id_ex_flush", int'(id_ex_flush), int'(e_idf));
    if (!r) begin
      if (clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (!e_pc && m_stall < CMAX) m_stall++;
        if (e_iff && m_flush < CMAX) m_flush++;
      end
    end
  endtask

  task automatic idle(input bit imr);
    step(0, 0, 1'b0, 1'b0, 0, 1'b0, imr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    step(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic after_edge(input string tag, input int obs_sel, input int exp);
    @(posedge clk);
    #1;
    check_eq(tag, (obs_sel == 0) ? int'(stall_cnt) : int'(flush_cnt), exp);
  endtask

  initial begin
    // Reset
    step(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // T1 load-use on rs, then bubble in EX; ex_rt=0 never stalls
    step(8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 9, 1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 9, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // T2 redirect with two fetch bubbles
    clear_stats();
    step(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    after_edge("t2_flush_cnt", 1, 3);
    idle(1'b1);

    // T3 imem not ready during bubbles holds the bubble count
    clear_stats();
    step(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    after_edge("t3_stall_cnt", 0, 3);
    idle(1'b1);

    // T4 dmem freeze with redirect held in EX
    clear_stats();
    for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge("t4_stall_cnt", 0, 4);
    idle(1'b1);
    idle(1'b1);

    // T5 freeze beats load-use, stall follows
    step(4, 0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4, 0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // T6 saturation, clear, then reset in the middle of redirect bubbles
    clear_stats();
    for (int i = 0; i < 20; i++) idle(1'b0);
    after_edge("t6_stall_sat", 0, CMAX);
    clear_stats();
    after_edge("t6_stall_clr", 0, 0);
    step(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic; redirect only offered while no bubbles are owed
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      rd = (m_bub == 0) && ($urandom_range(7) == 0);
      step($urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
           1'($urandom_range(1)), $urandom_range(3), rd,
           $urandom_range(3) != 0, $urandom_range(5) == 0,
           $urandom_range(49) == 0, $urandom_range(99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
